uart_rx_controller: RTL

Receive-side counterpart of the transmit controller: it takes bytes from the UART receiver's `rdy`/`dout`/`rdy_clr` handshake and buffers them in a FIFO. The CPU reads them through a memory-mapped status/data window in the control address space (`Address[16]` = 1). It sits between `uart` and the CPU read-data mux, on the same 25 MHz domain as `Processor`, `RAM` and the transmit `Controller`.

---
 rtl/uart_rx_pkg.sv | 37 +++
 rtl/sync_fifo.sv | 65 ++++++
 rtl/uart_rx_controller.sv | 124 ++++++++++++
 3 files changed

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive controller: register map, status layout, capture states.
package uart_rx_pkg;

    localparam logic        REG_STATUS   = 1'b0;
    localparam logic        REG_DATA     = 1'b1;

    localparam int unsigned ST_NE        = 0;
    localparam int unsigned ST_FULL      = 1;
    localparam int unsigned ST_OVF       = 2;
    localparam int unsigned ST_COUNT_LSB = 8;
    localparam int unsigned ST_COUNT_W   = 8;

    localparam logic [31:0] EMPTY_READ   = 32'h8000_0000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACK   = 2'd1,
        S_DRAIN = 2'd2
    } cap_state_t;

    // Packs the flags and occupancy into the STATUS word; unused bits read 0.
    function automatic logic [31:0] status_word(
        input logic                  ne,
        input logic                  full,
        input logic                  ovf,
        input logic [ST_COUNT_W-1:0] count
    );
        logic [31:0] w;
        w          = '0;
        w[ST_NE]   = ne;
        w[ST_FULL] = full;
        w[ST_OVF]  = ovf;
        w[ST_COUNT_LSB +: ST_COUNT_W] = count;
        return w;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; a pop frees a slot for a same-cycle push, and a pop on empty is ignored.
module sync_fifo #(
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned DEPTH = 16,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout_c,
    output logic             o_full,
    output logic             o_not_empty,
    output logic [AW:0]      o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             r_full;
    logic             r_not_empty;

    logic             w_do_pop;
    logic             w_do_push;
    logic [AW:0]      w_count_next;

    assign w_do_pop     = i_pop & r_not_empty;
    assign w_do_push    = i_push & (~r_full | w_do_pop);
    assign w_count_next = r_count + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    // Flags are registered from the next count so they track the count exactly.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_full      <= 1'b0;
            r_not_empty <= 1'b0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count     <= w_count_next;
            r_full      <= (w_count_next == (AW+1)'(DEPTH));
            r_not_empty <= (w_count_next != '0);
        end
    end

    assign o_dout_c    = r_mem[r_rd_ptr];
    assign o_full      = r_full;
    assign o_not_empty = r_not_empty;
    assign o_count     = r_count;

endmodule

// File: rtl/uart_rx_controller.sv
// Captures UART receiver bytes into a FIFO and exposes them to the CPU via a STATUS/DATA window.
module uart_rx_controller
    import uart_rx_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic        Clock,
    input  logic        Reset_n,
    input  logic        Rx_Ready,
    input  logic [7:0]  Rx_Data,
    output logic        Rx_Clear,
    input  logic        Sel,
    input  logic        Reg_Addr,
    input  logic        ReadEnable,
    input  logic        WriteEnable,
    input  logic [31:0] Data_In,
    output logic [31:0] Data_Out,
    output logic        Irq
);

    localparam int unsigned AW = $clog2(DEPTH);

    cap_state_t  r_state;
    logic        r_rx_clear;
    logic        r_ovf;
    logic [31:0] r_data_out;

    logic        w_push;
    logic        w_rd;
    logic        w_wr;
    logic        w_pop;
    logic        w_ovf_set;
    logic        w_ovf_clr;
    logic        w_full;
    logic        w_ne;
    logic [AW:0] w_count;
    logic [7:0]  w_fifo_dout;
    logic [31:0] w_status;
    logic        w_unused_data_in;

    assign w_push    = (r_state == S_IDLE) & Rx_Ready;
    assign w_rd      = Sel & ReadEnable;
    assign w_wr      = Sel & WriteEnable;
    assign w_pop     = w_rd & (Reg_Addr == REG_DATA) & w_ne;
    // A full FIFO always has data, so a same-cycle pop always frees the slot.
    assign w_ovf_set = w_push & w_full & ~w_pop;
    assign w_ovf_clr = w_wr & (Reg_Addr == REG_STATUS) & Data_In[ST_OVF];
    assign w_status  = status_word(w_ne, w_full, r_ovf, ST_COUNT_W'(w_count));

    assign w_unused_data_in = &{1'b0, Data_In[31:3], Data_In[1:0]};

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk       (Clock),
        .i_rst_n     (Reset_n),
        .i_push      (w_push),
        .i_din       (Rx_Data),
        .i_pop       (w_pop),
        .o_dout_c    (w_fifo_dout),
        .o_full      (w_full),
        .o_not_empty (w_ne),
        .o_count     (w_count)
    );

    // Capture FSM: one push and one rdy_clr pulse per byte, then wait for rdy to drop.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state    <= S_IDLE;
            r_rx_clear <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (Rx_Ready) begin
                        r_state    <= S_ACK;
                        r_rx_clear <= 1'b1;
                    end
                end
                S_ACK: begin
                    r_state    <= S_DRAIN;
                    r_rx_clear <= 1'b0;
                end
                S_DRAIN: begin
                    if (!Rx_Ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_rx_clear <= 1'b0;
                end
            endcase
        end
    end

    // Sticky overflow (set beats clear) and the registered read mux.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_ovf      <= 1'b0;
            r_data_out <= '0;
        end else begin
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (w_ovf_clr) begin
                r_ovf <= 1'b0;
            end
            if (w_rd) begin
                if (Reg_Addr == REG_STATUS) begin
                    r_data_out <= w_status;
                end else if (w_ne) begin
                    r_data_out <= {24'h0, w_fifo_dout};
                end else begin
                    r_data_out <= EMPTY_READ;
                end
            end
        end
    end

    assign Rx_Clear = r_rx_clear;
    assign Data_Out = r_data_out;
    assign Irq      = w_ne;

endmodule
